// File: rtl/gat_pkg.sv
// Shared constants and types for the GAT input loader.
// Region geometry here must track the memory_controller BRAM sizes.
package gat_pkg;

    localparam int NUM_LOAD_REGIONS = 5;

    localparam int H_DATA_WIDTH    = 64;
    localparam int NODE_INFO_WIDTH = 40;
    localparam int DATA_WIDTH      = 32;
    localparam int NUM_NODE_WIDTH  = 16;

    localparam int H_DATA_DEPTH    = 16;
    localparam int NODE_INFO_DEPTH = 16;
    localparam int WEIGHT_DEPTH    = 16;
    localparam int A_DEPTH         = 16;
    localparam int NUM_NODE_DEPTH  = 4;

    localparam int LOAD_W [NUM_LOAD_REGIONS] = '{
        H_DATA_WIDTH, NODE_INFO_WIDTH, DATA_WIDTH,
        DATA_WIDTH, NUM_NODE_WIDTH
    };

    localparam int LOAD_DEPTH [NUM_LOAD_REGIONS] = '{
        H_DATA_DEPTH, NODE_INFO_DEPTH, WEIGHT_DEPTH,
        A_DEPTH, NUM_NODE_DEPTH
    };

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_HDR,
        LD_DATA,
        LD_CHK,
        LD_FLUSH,
        LD_DONE,
        LD_ERR
    } load_state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_COUNT,
        ERR_FRAME,
        ERR_CSUM
    } load_err_e;

    function automatic int load_w(input int r);
        return LOAD_W[r];
    endfunction

    function automatic int load_depth(input int r);
        return LOAD_DEPTH[r];
    endfunction

    function automatic int load_bpe(input int r, input int din_w);
        return (LOAD_W[r] + din_w - 1) / din_w;
    endfunction

endpackage

// File: rtl/beat_assembler.sv
// Little-endian beat packer: first beat lands in the low DIN_W bits.
// MAX_W must be a multiple of DIN_W.
module beat_assembler #(
    parameter int DIN_W = 32,
    parameter int MAX_W = 64,
    parameter int BPE_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             beat_vld,
    input  logic [DIN_W-1:0] beat,
    input  logic [BPE_W-1:0] bpe,
    output logic [MAX_W-1:0] entry,
    output logic             entry_vld
);

    localparam int NB = MAX_W / DIN_W;

    logic [MAX_W-1:0] acc_q;
    logic [BPE_W-1:0] cnt_q;

    // entry is the word as it will look once the current beat is merged
    always_comb begin
        entry = acc_q;
        for (int i = 0; i < NB; i++) begin
            if (cnt_q == BPE_W'(i)) begin
                entry[i*DIN_W +: DIN_W] = beat;
            end
        end
    end

    assign entry_vld = beat_vld && (cnt_q == bpe - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (beat_vld) begin
            if (entry_vld) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= entry;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gat_input_loader.sv
// PS->PL stream loader filling the five GAT BRAM regions in order.
// Optional per-region XOR trailer beat: define LOAD_CHECKSUM_EN.
module gat_input_loader
    import gat_pkg::*;
#(
    parameter int DIN_W  = 32,
    parameter int MAX_W  = 64,
    parameter int ADDR_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [DIN_W-1:0]            s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_last,
    output logic [MAX_W-1:0]            wr_data,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [NUM_LOAD_REGIONS-1:0] wr_ena,
    output logic [NUM_LOAD_REGIONS-1:0] load_done,
    output logic                        busy,
    output logic                        all_done,
    output logic                        err,
    output logic [1:0]                  err_code
);

    localparam int NB    = MAX_W / DIN_W;
    localparam int BPE_W = $clog2(NB + 1);
    localparam int LAST  = NUM_LOAD_REGIONS - 1;

`ifdef LOAD_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    load_state_e state, state_n;
    load_err_e   err_n;

    logic [2:0]                  region;
    logic [ADDR_W-1:0]           cnt, idx, hdr_cnt;
    logic [NUM_LOAD_REGIONS-1:0] reg_oh, done_q, done_set;
    logic [MAX_W-1:0]            entry, masked;
    logic [BPE_W-1:0]            bpe;
    logic acc, entry_vld, last_reg, last_ent;
    logic go_start, go_err, hdr_take, fire;
    logic reg_end, mark_now;

    assign s_ready = (state == LD_HDR) || (state == LD_DATA)
                  || (state == LD_CHK);
    assign busy    = s_ready || (state == LD_FLUSH);
    assign acc     = s_valid && s_ready;

    assign hdr_cnt  = s_data[ADDR_W-1:0];
    assign reg_oh   = NUM_LOAD_REGIONS'(1) << region;
    assign last_reg = (region == 3'(LAST));
    assign last_ent = (idx == cnt - 1'b1);
    assign bpe      = BPE_W'(load_bpe(int'(region), DIN_W));

    beat_assembler #(
        .DIN_W (DIN_W),
        .MAX_W (MAX_W),
        .BPE_W (BPE_W)
    ) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (go_start || hdr_take),
        .beat_vld  (acc && (state == LD_DATA)),
        .beat      (s_data),
        .bpe       (bpe),
        .entry     (entry),
        .entry_vld (entry_vld)
    );

    always_comb begin
        masked = '0;
        for (int i = 0; i < MAX_W; i++) begin
            masked[i] = entry[i] && (i < load_w(int'(region)));
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [DIN_W-1:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (go_start || hdr_take) begin
            csum <= '0;
        end else if (acc && (state == LD_DATA)) begin
            csum <= csum ^ s_data;
        end
    end
`endif

    always_comb begin
        state_n  = state;
        err_n    = ERR_NONE;
        go_start = 1'b0;
        go_err   = 1'b0;
        hdr_take = 1'b0;
        fire     = 1'b0;
        reg_end  = 1'b0;
        mark_now = 1'b0;
        unique case (state)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) begin
                    go_start = 1'b1;
                    state_n  = LD_HDR;
                end
            end
            LD_HDR: begin
                if (acc) begin
                    if (hdr_cnt >
                        ADDR_W'(load_depth(int'(region)))) begin
                        go_err = 1'b1;
                        err_n  = ERR_COUNT;
                    end else if (s_last != (last_reg && !CHK_EN
                                 && hdr_cnt == '0)) begin
                        go_err = 1'b1;
                        err_n  = ERR_FRAME;
                    end else begin
                        hdr_take = 1'b1;
                        if (hdr_cnt != '0) begin
                            state_n = LD_DATA;
                        end else if (CHK_EN) begin
                            state_n = LD_CHK;
                        end else begin
                            reg_end  = 1'b1;
                            mark_now = 1'b1;
                        end
                    end
                end
            end
            LD_DATA: begin
                if (acc) begin
                    if (s_last != (entry_vld && last_ent
                                   && last_reg && !CHK_EN)) begin
                        go_err = 1'b1;
                        err_n  = ERR_FRAME;
                    end else if (entry_vld) begin
                        fire = 1'b1;
                        if (last_ent) begin
                            if (CHK_EN) state_n = LD_CHK;
                            else        reg_end = 1'b1;
                        end
                    end
                end
            end
`ifdef LOAD_CHECKSUM_EN
            LD_CHK: begin
                if (acc) begin
                    if (s_data != csum) begin
                        go_err = 1'b1;
                        err_n  = ERR_CSUM;
                    end else if (s_last != last_reg) begin
                        go_err = 1'b1;
                        err_n  = ERR_FRAME;
                    end else begin
                        reg_end  = 1'b1;
                        mark_now = 1'b1;
                    end
                end
            end
`endif
            // last write still in flight; done lands one cycle later
            LD_FLUSH: begin
                if (done_q[LAST]) state_n = LD_DONE;
            end
            default: ;
        endcase
        if (reg_end) begin
            if (!last_reg)     state_n = LD_HDR;
            else if (mark_now) state_n = LD_DONE;
            else               state_n = LD_FLUSH;
        end
        if (go_err) state_n = LD_ERR;
    end

    assign done_set = done_q | (mark_now ? reg_oh : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LD_IDLE;
            region    <= '0;
            cnt       <= '0;
            idx       <= '0;
            done_q    <= '0;
            wr_data   <= '0;
            wr_addr   <= '0;
            wr_ena    <= '0;
            load_done <= '0;
            all_done  <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            state  <= state_n;
            wr_ena <= fire ? reg_oh : '0;
            if (fire) begin
                wr_data <= masked;
                wr_addr <= idx;
                idx     <= idx + 1'b1;
            end
            if (hdr_take) begin
                cnt <= hdr_cnt;
                idx <= '0;
            end
            if (reg_end && !last_reg) region <= region + 1'b1;
            done_q    <= (reg_end && !mark_now) ? reg_oh : '0;
            load_done <= load_done | done_set;
            if (done_set[LAST]) all_done <= 1'b1;
            if (go_err) begin
                err      <= 1'b1;
                err_code <= err_n;
            end
            if (go_start) begin
                region    <= '0;
                done_q    <= '0;
                load_done <= '0;
                all_done  <= 1'b0;
                err       <= 1'b0;
                err_code  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gat_input_loader.sv
// Self-checking bench for gat_input_loader: vector table, hand sequences,
// random data and s_valid gaps against a stream-level reference model.
module tb_gat_input_loader;
    import gat_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [63:0] wr_data;
    logic [15:0] wr_addr;
    logic [4:0]  wr_ena;
    logic [4:0]  load_done;
    logic        busy;
    logic        all_done;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    gat_input_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_ena    (wr_ena),
        .load_done (load_done),
        .busy      (busy),
        .all_done  (all_done),
        .err       (err),
        .err_code  (err_code)
    );

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] a;
        logic [63:0] d;
    } wr_t;

    typedef struct {
        int         n [5];
        int         corrupt;
        bit         gaps;
        logic [4:0] done;
        logic [1:0] code;
    } vec_t;

    wr_t         exp_q [$];
    wr_t         got_q [$];
    logic [31:0] beat_q [$];
    bit          last_q [$];
    int          end_idx [5];
    int          wbits [5] = '{64, 40, 32, 32, 16};
    int          pass_cnt = 0;
    int          total = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endtask

    function automatic logic [63:0] wmask(input int w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic vec_t mk(input int n0, n1, n2, n3, n4,
                                input int corrupt, input bit gaps,
                                input logic [4:0] done,
                                input logic [1:0] code);
        vec_t v;
        v.n = '{n0, n1, n2, n3, n4};
        v.corrupt = corrupt;
        v.gaps = gaps;
        v.done = done;
        v.code = code;
        return v;
    endfunction

    always @(negedge clk) begin : mon
        wr_t w;
        if (rst_n && wr_ena != '0) begin
            chk("wr_ena_onehot", 64'($onehot(wr_ena)), 64'd1);
            w.r = '0;
            for (int i = 0; i < 5; i++) if (wr_ena[i]) w.r = 3'(i);
            w.a = wr_addr;
            w.d = wr_data;
            got_q.push_back(w);
        end
    end

    // Reference stream + expected writes from region counts
    task automatic build(input int n [5], input int corrupt);
        logic [63:0] v;
        logic [31:0] cs, bt;
        int bpe;
        bit ok;
        wr_t w;
        beat_q.delete();
        last_q.delete();
        exp_q.delete();
        ok = 1'b1;
        for (int r = 0; r < 5; r++) begin
            beat_q.push_back({16'($urandom), 16'(n[r])});
            if (n[r] > LOAD_DEPTH[r]) begin
                ok = 1'b0;
                break;
            end
            cs = '0;
            bpe = (wbits[r] + 31) / 32;
            for (int i = 0; i < n[r]; i++) begin
                v = {$urandom, $urandom};
                for (int k = 0; k < bpe; k++) begin
                    bt = v[32*k +: 32];
                    beat_q.push_back(bt);
                    cs ^= bt;
                end
                w.r = 3'(r);
                w.a = 16'(i);
                w.d = v & wmask(wbits[r]);
                exp_q.push_back(w);
            end
`ifdef LOAD_CHECKSUM_EN
            beat_q.push_back(corrupt == r ? ~cs : cs);
            if (corrupt == r) begin
                ok = 1'b0;
                break;
            end
`else
            if (corrupt == r) ok = 1'b0;
`endif
            end_idx[r] = beat_q.size() - 1;
        end
        foreach (beat_q[i]) last_q.push_back(1'b0);
        if (ok) last_q[last_q.size()-1] = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input bit last,
                        input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                start = ($urandom_range(0, 2) == 0);
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        s_data = d;
        s_valid = 1'b1;
        s_last = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 20) break;
        end
        if (n > 20) begin
            total++;
            $display("FAIL accept_timeout got=stalled expected=accept");
        end else begin
            @(posedge clk);
        end
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic run_stream(input bit gaps);
        int n;
        got_q.delete();
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        foreach (beat_q[i]) send(beat_q[i], last_q[i], gaps);
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [4:0] done,
                                input logic [1:0] code);
        chk({tag, "_load_done"}, 64'(load_done), 64'(done));
        chk({tag, "_err_code"}, 64'(err_code), 64'(code));
        chk({tag, "_err"}, 64'(err), 64'(code != 2'd0));
        chk({tag, "_all_done"}, 64'(all_done), 64'(done == 5'h1f));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_writes(input string tag);
        int m;
        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        m = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk({tag, "_wr_ra"}, 64'({got_q[i].r, got_q[i].a}),
                64'({exp_q[i].r, exp_q[i].a}));
            chk({tag, "_wr_data"}, got_q[i].d, exp_q[i].d);
        end
    endtask

    vec_t tbl [$];

    initial begin
        tbl.push_back(mk(4, 4, 8, 2, 3, -1, 0, 5'h1f, 2'd0));
        tbl.push_back(mk(4, 4, 8, 2, 3, -1, 1, 5'h1f, 2'd0));
        tbl.push_back(mk(1, 2, LOAD_DEPTH[2] + 1, 1, 1, -1, 0,
                         5'h03, 2'd1));
        tbl.push_back(mk(0, 1, 0, 0, 0, -1, 1, 5'h1f, 2'd0));
        tbl.push_back(mk(LOAD_DEPTH[0], LOAD_DEPTH[1], LOAD_DEPTH[2],
                         LOAD_DEPTH[3], LOAD_DEPTH[4], -1, 1,
                         5'h1f, 2'd0));
        tbl.push_back(mk(1, 1, 1, 1, LOAD_DEPTH[4] + 1, -1, 0,
                         5'h0f, 2'd1));
`ifdef LOAD_CHECKSUM_EN
        tbl.push_back(mk(4, 4, 8, 2, 3, 3, 0, 5'h07, 2'd3));
`endif

        // reset state
        #2;
        chk("rst_wr_ena", 64'(wr_ena), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_flags", 64'({busy, all_done, err, err_code, s_ready}),
            64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            build(tbl[i].n, tbl[i].corrupt);
            run_stream(tbl[i].gaps);
            check_status($sformatf("vec%0d", i), tbl[i].done, tbl[i].code);
            check_writes($sformatf("vec%0d", i));
        end

        // single H_DATA entry, exact write timing
        pulse_start();
        send(32'h0000_0001, 1'b0, 1'b0);
        send(32'h1111_1111, 1'b0, 1'b0);
        send(32'h2222_2222, 1'b0, 1'b0);
        chk("hd_wr_ena", 64'(wr_ena), 64'h01);
        chk("hd_wr_data", wr_data, 64'h2222_2222_1111_1111);
        chk("hd_wr_addr", 64'(wr_addr), 64'd0);
        @(posedge clk);
        #1;
        chk("hd_wr_ena_off", 64'(wr_ena), 64'd0);
`ifdef LOAD_CHECKSUM_EN
        send(32'h3333_3333, 1'b0, 1'b0);
`endif
        chk("hd_load_done", 64'(load_done), 64'h01);
        for (int r = 1; r < 5; r++) begin
            if (r == 4) chk("hd_not_all", 64'(all_done), 64'd0);
`ifdef LOAD_CHECKSUM_EN
            send(32'h0, 1'b0, 1'b0);
            send(32'h0, r == 4, 1'b0);
`else
            send(32'h0, r == 4, 1'b0);
`endif
        end
        chk("hd_all_load_done", 64'(load_done), 64'h1f);
        chk("hd_all_done", 64'(all_done), 64'd1);
        chk("hd_busy_off", 64'(busy), 64'd0);

        // s_last early on last beat of region 1
        build('{2, 3, 1, 1, 1}, -1);
        while (beat_q.size() > end_idx[1] + 1) begin
            void'(beat_q.pop_back());
            void'(last_q.pop_back());
        end
        last_q[last_q.size()-1] = 1'b1;
        run_stream(1'b0);
        check_status("frame_early", 5'h01, 2'd2);

        // final beat lacks s_last
        build('{2, 3, 1, 1, 1}, -1);
        last_q[last_q.size()-1] = 1'b0;
        run_stream(1'b0);
        check_status("frame_missing", 5'h0f, 2'd2);

        // reset mid-load drops partial progress
        build('{4, 4, 8, 2, 3}, -1);
        pulse_start();
        for (int i = 0; i < 10; i++) send(beat_q[i], 1'b0, 1'b0);
        chk("mid_load_done", 64'(load_done), 64'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_load_done", 64'(load_done), 64'd0);
        chk("mid_rst_flags", 64'({busy, s_ready, wr_ena}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_idle", 64'({busy, s_ready, all_done, err}), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
